// File: rtl/correlation_feeder_if.sv
// Bundle of the correlation feeder's stream, bus and result signals.
// slave is the feeder's view; master is the surrounding environment's view.
interface correlation_feeder_if #(
  parameter int unsigned TAPS = 10,
  parameter int unsigned DW   = 4,
  parameter int unsigned YW   = 12
);
  logic                 coef_valid;
  logic [DW-1:0]        coef_data;
  logic                 coef_ready;
  logic                 s_valid;
  logic [DW-1:0]        s_data;
  logic                 s_ready;
  logic                 reload;
  logic [TAPS*DW-1:0]   x_bus;
  logic [TAPS*DW-1:0]   h_bus;
  logic [YW-1:0]        corr_y;
  logic                 m_valid;
  logic [YW-1:0]        m_data;
  logic                 m_ready;

  modport slave (
    input  coef_valid, coef_data, s_valid, s_data, reload, corr_y, m_ready,
    output coef_ready, s_ready, x_bus, h_bus, m_valid, m_data
  );

  modport master (
    output coef_valid, coef_data, s_valid, s_data, reload, corr_y, m_ready,
    input  coef_ready, s_ready, x_bus, h_bus, m_valid, m_data
  );
endinterface

// File: rtl/correlation_feeder.sv
// Front/back end for the correlator datapath: serial coefficient load onto a static h bus,
// sliding sample window onto the x bus, and a result FIFO that captures corr_y LAT edges
// after each launched window.
module correlation_feeder #(
  parameter int unsigned TAPS  = 10,
  parameter int unsigned DW    = 4,
  parameter int unsigned YW    = 12,
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  correlation_feeder_if.slave  bus_io
);

  localparam int unsigned CntW   = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CountW = $clog2(DEPTH + 1);
  localparam int unsigned OccW   = $clog2(DEPTH + LAT + 1);

  typedef enum logic [1:0] {StLoadCoef, StFill, StRun, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [TAPS-1:0][DW-1:0] x_q, x_d;
  logic [TAPS-1:0][DW-1:0] h_q, h_d;
  logic [LAT-1:0]          tag_q, tag_d;

  logic [YW-1:0]           mem_q [DEPTH];
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0]       count_q, count_d;

  logic [OccW-1:0]         occupancy;
  logic                    s_ready;
  logic                    accept;
  logic                    launch;
  logic                    push;
  logic                    pop;

  // Credit check: each result already queued or still in the tag pipe owns a FIFO slot,
  // so a launched window can never find the FIFO full when its result arrives.
  always_comb begin
    occupancy = OccW'(count_q);
    for (int i = 0; i < int'(LAT); i++) begin
      occupancy = occupancy + OccW'(tag_q[i]);
    end
    s_ready = ((state_q == StFill) || (state_q == StRun)) && (occupancy < OccW'(DEPTH));
    accept  = s_ready && bus_io.s_valid;
  end

  // Next state, coefficient writes, window shift and launch decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    h_d     = h_q;
    launch  = 1'b0;

    // Window shifts toward x_0; the newest sample enters at the top slice.
    if (accept) begin
      x_d = {bus_io.s_data, x_q[TAPS-1:1]};
    end

    case (state_q)
      StLoadCoef: begin
        if (bus_io.coef_valid) begin
          h_d[cnt_q] = bus_io.coef_data;
          if (cnt_q == CntW'(TAPS - 1)) begin
            state_d = StFill;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StFill: begin
        if (accept) begin
          if (cnt_q == CntW'(TAPS - 2)) begin
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        if (bus_io.reload) begin
          state_d = StDrain;
        end
      end
      StRun: begin
        launch = accept;
        if (bus_io.reload) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Wait for every launched window's result to land before clearing the window.
        if (tag_q == '0) begin
          state_d = StLoadCoef;
          x_d     = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StLoadCoef;
      end
    endcase

    tag_d = (tag_q << 1) | LAT'(launch);
  end

  // FSM, window, coefficient and launch-tag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StLoadCoef;
      cnt_q   <= '0;
      x_q     <= '0;
      h_q     <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      h_q     <= h_d;
      tag_q   <= tag_d;
    end
  end

  // FIFO pointer and occupancy bookkeeping; a tag leaving the pipe is a push.
  always_comb begin
    push     = tag_q[LAT-1];
    pop      = (count_q != '0) && bus_io.m_ready;
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CountW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CountW'(1);
    end
  end

  // FIFO pointers and count.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus_io.corr_y;
    end
  end

  assign bus_io.coef_ready = (state_q == StLoadCoef);
  assign bus_io.s_ready    = s_ready;
  assign bus_io.x_bus      = x_q;
  assign bus_io.h_bus      = h_q;
  assign bus_io.m_valid    = (count_q != '0);
  assign bus_io.m_data     = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_correlation_feeder.sv
// Self-checking bench for correlation_feeder with a behavioural two-stage correlator.
module tb_correlation_feeder;
  localparam int TAPS = 10;
  localparam int DW   = 4;
  localparam int YW   = 12;
  localparam int HW   = TAPS * DW;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  correlation_feeder_if #(.TAPS(TAPS), .DW(DW), .YW(YW)) bus_if ();

  correlation_feeder #(
    .TAPS (TAPS),
    .DW   (DW),
    .YW   (YW),
    .LAT  (2),
    .DEPTH(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus_io(bus_if)
  );

  // Correlator model: products registered at posedge, result visible one edge later.
  logic [YW-1:0] corr_q;

  function automatic logic [YW-1:0] dot(input logic [HW-1:0] x, input logic [HW-1:0] h);
    int acc;
    acc = 0;
    for (int k = 0; k < TAPS; k++) begin
      acc += int'(x[k*DW +: DW]) * int'(h[k*DW +: DW]);
    end
    return YW'(acc);
  endfunction

  always @(posedge clock) corr_q <= dot(bus_if.x_bus, bus_if.h_bus);
  assign bus_if.corr_y = corr_q;

  // Result monitor: a pop happens at the next posedge when valid and ready are both high.
  logic [YW-1:0] got[$];
  int            pop_cyc[$];
  int            cyc_cnt = 0;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  always begin
    @(negedge clock);
    #1;
    if (bus_if.m_valid && bus_if.m_ready && !reset) begin
      got.push_back(bus_if.m_data);
      pop_cyc.push_back(cyc_cnt);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic do_reset();
    reset             = 1'b1;
    bus_if.coef_valid = 1'b0;
    bus_if.coef_data  = '0;
    bus_if.s_valid    = 1'b0;
    bus_if.s_data     = '0;
    bus_if.reload     = 1'b0;
    bus_if.m_ready    = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    got.delete();
    pop_cyc.delete();
  endtask

  task automatic load_range(input logic [HW-1:0] hv, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      @(negedge clock);
      bus_if.coef_valid = 1'b1;
      bus_if.coef_data  = hv[k*DW +: DW];
    end
    @(negedge clock);
    bus_if.coef_valid = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    int n;
    n = 0;
    @(negedge clock);
    while (!bus_if.s_ready && n < 64) begin
      @(negedge clock);
      n++;
    end
    if (n >= 64) begin
      check("send_s_ready", bus_if.s_ready, 1);
      return;
    end
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = d;
    @(posedge clock);
    #1;
    bus_if.s_valid = 1'b0;
  endtask

  task automatic wait_got(input string name, input int n, input int bound);
    int c;
    c = 0;
    while (got.size() < n && c < bound) begin
      @(negedge clock);
      c++;
    end
    check(name, got.size(), n);
  endtask

  typedef struct {
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          m_ready;
    logic          exp_s_ready;
    logic          exp_m_valid;
    logic [YW-1:0] exp_m_data;
  } vec_t;

  function automatic vec_t mk(input logic sv, input int sd, input logic mr, input logic esr,
                              input logic emv, input int emd);
    vec_t v;
    v.s_valid     = sv;
    v.s_data      = DW'(sd);
    v.m_ready     = mr;
    v.exp_s_ready = esr;
    v.exp_m_valid = emv;
    v.exp_m_data  = YW'(emd);
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: still running at %0t, limit 2000000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t          vecs[$];
    logic [HW-1:0] h_ramp;
    logic [HW-1:0] h_ones;
    logic [HW-1:0] h_max;
    logic [DW-1:0] samp[20];
    logic [DW-1:0] win[TAPS];
    int            exp_q[$];
    int            idx;
    int            c;
    int            acc;

    for (int k = 0; k < TAPS; k++) begin
      h_ramp[k*DW +: DW] = DW'(k);
      h_ones[k*DW +: DW] = DW'(1);
      h_max[k*DW +: DW]  = DW'(15);
    end

    // Test 1 vectors: h=0..9, samples 1..10 give 330; then 11 gives 375.
    for (int i = 0; i < 10; i++) vecs.push_back(mk(1, i + 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 11, 1, 1, 1, 330));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 375));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0));

    // Reset state.
    do_reset();
    check("rst_coef_ready", bus_if.coef_ready, 1);
    check("rst_s_ready", bus_if.s_ready, 0);
    check("rst_m_valid", bus_if.m_valid, 0);
    check("rst_x_bus", bus_if.x_bus, 0);
    check("rst_h_bus", bus_if.h_bus, 0);

    // Test 1: table-driven ramp.
    load_range(h_ramp, 0, TAPS - 1);
    check("t1_h_bus", bus_if.h_bus, h_ramp);
    check("t1_coef_ready_low", bus_if.coef_ready, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      check($sformatf("t1_row%0d_s_ready", i), bus_if.s_ready, vecs[i].exp_s_ready);
      check($sformatf("t1_row%0d_m_valid", i), bus_if.m_valid, vecs[i].exp_m_valid);
      if (vecs[i].exp_m_valid) begin
        check($sformatf("t1_row%0d_m_data", i), bus_if.m_data, vecs[i].exp_m_data);
      end
      bus_if.s_valid = vecs[i].s_valid;
      bus_if.s_data  = vecs[i].s_data;
      bus_if.m_ready = vecs[i].m_ready;
    end
    @(negedge clock);
    bus_if.s_valid = 1'b0;

    // Test 2: full-scale values, back-to-back windows give one result per cycle.
    do_reset();
    bus_if.m_ready = 1'b1;
    load_range(h_max, 0, TAPS - 1);
    for (int i = 0; i < TAPS - 1; i++) send(4'd15);
    for (int i = 0; i < 6; i++) send(4'd15);
    wait_got("t2_count", 6, 20);
    for (int i = 0; i < got.size(); i++) check($sformatf("t2_res%0d", i), got[i], 2250);
    if (pop_cyc.size() >= 6) check("t2_one_per_cycle", pop_cyc[5] - pop_cyc[0], 5);

    // Test 3: backpressure; four windows in flight stall the sample stream.
    do_reset();
    load_range(h_ones, 0, TAPS - 1);
    for (int k = 0; k < TAPS; k++) win[k] = '0;
    for (int i = 0; i < TAPS - 1; i++) begin
      send(DW'(i + 1));
      for (int k = 0; k < TAPS - 1; k++) win[k] = win[k+1];
      win[TAPS-1] = DW'(i + 1);
    end
    exp_q.delete();
    for (int j = 0; j < 20; j++) begin
      samp[j] = DW'((j + 9) % 15 + 1);
      for (int k = 0; k < TAPS - 1; k++) win[k] = win[k+1];
      win[TAPS-1] = samp[j];
      acc = 0;
      for (int k = 0; k < TAPS; k++) acc += int'(win[k]);
      exp_q.push_back(acc);
    end
    idx = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clock);
      if (cyc == 25) begin
        check("t3_stall_s_ready", bus_if.s_ready, 0);
        check("t3_launched", idx, 4);
        check("t3_fifo_valid", bus_if.m_valid, 1);
        check("t3_none_popped", got.size(), 0);
        bus_if.m_ready = 1'b1;
      end
      if (cyc == 26) check("t3_s_ready_back", bus_if.s_ready, 1);
      if (idx < 20) begin
        bus_if.s_valid = 1'b1;
        bus_if.s_data  = samp[idx];
        if (bus_if.s_ready) idx++;
      end else begin
        bus_if.s_valid = 1'b0;
        if (got.size() >= 20) break;
      end
    end
    bus_if.s_valid = 1'b0;
    check("t3_count", got.size(), 20);
    for (int i = 0; i < got.size() && i < 20; i++) begin
      check($sformatf("t3_res%0d", i), got[i], exp_q[i]);
    end

    // Test 4: reload with two windows in flight; both results still arrive.
    do_reset();
    bus_if.m_ready = 1'b1;
    load_range(h_ramp, 0, TAPS - 1);
    for (int i = 0; i < TAPS - 1; i++) send(DW'(i + 1));
    send(4'd10);
    send(4'd11);
    @(negedge clock);
    bus_if.reload = 1'b1;
    @(negedge clock);
    bus_if.reload = 1'b0;
    check("t4_drain_s_ready", bus_if.s_ready, 0);
    check("t4_drain_coef_ready", bus_if.coef_ready, 0);
    c = 0;
    while (!bus_if.coef_ready && c < 20) begin
      @(negedge clock);
      c++;
    end
    check("t4_coef_ready", bus_if.coef_ready, 1);
    check("t4_x_cleared", bus_if.x_bus, 0);
    check("t4_count", got.size(), 2);
    if (got.size() >= 2) begin
      check("t4_res0", got[0], 330);
      check("t4_res1", got[1], 375);
    end
    load_range(h_ones, 0, TAPS - 1);
    for (int i = 0; i < TAPS; i++) send(DW'(i + 1));
    wait_got("t4_reload_count", 3, 10);
    if (got.size() >= 3) check("t4_reload_res", got[2], 55);

    // Test 5: reset mid-run with a queued result.
    do_reset();
    load_range(h_ramp, 0, TAPS - 1);
    for (int i = 0; i < TAPS; i++) send(DW'(i + 1));
    repeat (3) @(negedge clock);
    check("t5_fifo_nonempty", bus_if.m_valid, 1);
    reset = 1'b1;
    @(negedge clock);
    check("t5_m_valid", bus_if.m_valid, 0);
    check("t5_coef_ready", bus_if.coef_ready, 1);
    check("t5_h_bus", bus_if.h_bus, 0);
    check("t5_x_bus", bus_if.x_bus, 0);
    reset = 1'b0;

    // Test 6a: coefficient beats during RUN are ignored.
    do_reset();
    bus_if.m_ready = 1'b1;
    load_range(h_ramp, 0, TAPS - 1);
    for (int i = 0; i < TAPS - 1; i++) send(DW'(i + 1));
    @(negedge clock);
    bus_if.coef_valid = 1'b1;
    bus_if.coef_data  = 4'd7;
    @(negedge clock);
    bus_if.coef_data  = 4'd3;
    @(negedge clock);
    bus_if.coef_valid = 1'b0;
    check("t6_h_unchanged", bus_if.h_bus, h_ramp);
    check("t6_coef_ready", bus_if.coef_ready, 0);
    check("t6_still_run", bus_if.s_ready, 1);
    send(4'd10);
    wait_got("t6_count", 1, 10);
    if (got.size() >= 1) check("t6_res", got[0], 330);

    // Test 6b: reload during coefficient load is ignored.
    do_reset();
    load_range(h_ramp, 0, 2);
    bus_if.reload = 1'b1;
    @(negedge clock);
    bus_if.reload = 1'b0;
    check("t6_reload_coef_ready", bus_if.coef_ready, 1);
    check("t6_reload_s_ready", bus_if.s_ready, 0);
    load_range(h_ramp, 3, TAPS - 1);
    check("t6_reload_h_bus", bus_if.h_bus, h_ramp);
    check("t6_reload_fill", bus_if.s_ready, 1);
    check("t6_reload_coef_low", bus_if.coef_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
